store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, byte-address width on both sides.
REQ-003 SHALL have clk  input  1  sole clock; all state on posedge clk.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have cpu_addr  input  ADDR_WIDTH  core byte address.
REQ-006 SHALL have cpu_write_data  input  32  core store data.
REQ-007 SHALL have cpu_memwrite / cpu_memread  input  1 each  core store/load request.
REQ-008 SHALL have cpu_sign_mask  input  4  access size/sign code ([3] signed, [2] word, [1] halfword, [0] byte).
REQ-009 SHALL have cpu_read_data  output  32  load result; cpu_stall  output  1  core hold.
REQ-010 SHALL have mem_addr (ADDR_WIDTH), mem_write_data (32), mem_memwrite (1), mem_memread (1), mem_sign_mask (4)  outputs  registered request to data memory.
REQ-011 SHALL have mem_read_data  input  32; mem_clk_stall  input  1  data-memory busy flag.

Function
REQ-012 SHALL hold a circular FIFO of DEPTH entries {addr, data, sign_mask}, write/read pointers wrapping at DEPTH, count 0..DEPTH.
REQ-013 SHALL accept a store when cpu_memwrite=1, cpu_memread=0 and count<DEPTH at cycle start; enqueue at that edge; cpu_stall=0 that cycle.
REQ-014 SHALL drive cpu_stall=1 combinationally while cpu_memwrite=1 and count==DEPTH; no bypass of a full FIFO by a same-cycle dequeue.
REQ-015 SHALL treat cpu_memread=1 with cpu_memwrite=1 as load only; store ignored.
REQ-016 SHALL use memory FSM states IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-017 IDLE: SHALL start a transaction only when mem_clk_stall=0; pending non-conflicting load has priority over FIFO drain; else drain head if count>0.
REQ-018 ISSUE: SHALL hold mem_memread or mem_memwrite high for exactly one cycle with the selected addr/data/sign_mask; then WAIT_HI.
REQ-019 WAIT_HI: SHALL remain until mem_clk_stall=1, then WAIT_LO.
REQ-020 WAIT_LO: on mem_clk_stall=0 SHALL complete: load -> capture mem_read_data into load register, set load_done; store -> dequeue head, count-1; then IDLE.
REQ-021 A store entry SHALL remain valid (for conflict checks) until its WAIT_LO completion.
REQ-022 Load conflict: cpu_addr[ADDR_WIDTH-1:2] equal to any valid entry's word address SHALL block the load until no conflicting entry remains; drain continues meanwhile.
REQ-023 cpu_stall SHALL be 1 while cpu_memread=1 and load_done=0; in the cycle load_done=1, cpu_stall=0 and cpu_read_data=load register; load_done clears at that edge.
REQ-024 Non-conflicting load latency from IDLE, data memory free: cpu_stall high cycles L..L+4, low at L+5.
REQ-025 Enqueue and dequeue in the same edge SHALL leave count unchanged.
REQ-026 mem_* request outputs SHALL be zero whenever not in ISSUE.

Reset
REQ-027 On reset: FSM IDLE, pointers 0, count 0, load_done 0, load register 0, all mem_* outputs 0, cpu_read_data 0, cpu_stall driven only by current inputs.
REQ-028 Reset mid-transaction SHALL discard FIFO contents and any in-flight load; no new request issued until mem_clk_stall=0 (REQ-017).

Verification
REQ-029 Reset for 2 cycles -> all outputs 0, count 0.
REQ-030 Store addr 0x004, data 0xDEADBEEF, mask 4'b0100 -> cpu_stall 0; next cycle single-cycle mem_memwrite with identical fields; count 0 after mem_clk_stall falls.
REQ-031 Five back-to-back stores, memory model 2-cycle busy -> first four no stall; fifth stalls until first completion, then accepted; memory sees all five in order.
REQ-032 Two stores queued (0x010, 0x014), load 0x020 word -> load issued before second store drains; cpu_stall high 5 cycles; cpu_read_data = model word at 0x020.
REQ-033 Store word 0x12345678 to 0x008, then halfword load 0x00A -> load waits until store completes, returns model result 0x00001234 (unsigned).
REQ-034 Reset asserted in WAIT_LO with mem_clk_stall=1 -> no mem_memread/mem_memwrite until mem_clk_stall=0; FIFO empty afterwards.

Source files
------------

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Brief    : Core-side and data-memory-side signal bundle of the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_write_data;
    logic                  cpu_memwrite;
    logic                  cpu_memread;
    logic [3:0]            cpu_sign_mask;
    logic [31:0]           cpu_read_data;
    logic                  cpu_stall;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_write_data;
    logic                  mem_memwrite;
    logic                  mem_memread;
    logic [3:0]            mem_sign_mask;
    logic [31:0]           mem_read_data;
    logic                  mem_clk_stall;

    // master: the core plus data memory surrounding the buffer
    modport master (
        output cpu_addr, cpu_write_data, cpu_memwrite, cpu_memread, cpu_sign_mask,
        output mem_read_data, mem_clk_stall,
        input  cpu_read_data, cpu_stall,
        input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
    );

    modport slave (
        input  cpu_addr, cpu_write_data, cpu_memwrite, cpu_memread, cpu_sign_mask,
        input  mem_read_data, mem_clk_stall,
        output cpu_read_data, cpu_stall,
        output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-store FIFO between core and data memory; loads bypass
//            queued stores unless they hit the same word.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
    logic [31:0]           r_fifo_data [DEPTH];
    logic [3:0]            r_fifo_mask [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_is_load;
    logic                  r_load_done;
    logic [31:0]           r_load_data;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic [3:0]            r_mem_mask;

    logic                  w_full;
    logic                  w_load_pending;
    logic                  w_conflict;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_start_load;
    logic                  w_start_store;
    logic                  w_complete;

    assign w_full         = (r_count == CNT_W'(DEPTH));
    assign w_load_pending = bus.cpu_memread & ~r_load_done;
    assign w_enq          = bus.cpu_memwrite & ~bus.cpu_memread & ~w_full;
    assign w_start_load   = (r_state == S_IDLE) & ~bus.mem_clk_stall & w_load_pending & ~w_conflict;
    assign w_start_store  = (r_state == S_IDLE) & ~bus.mem_clk_stall & ~w_start_load
                          & (r_count != '0);
    assign w_complete     = (r_state == S_WAIT_LO) & ~bus.mem_clk_stall;
    assign w_deq          = w_complete & ~r_is_load;

    // A slot is live when its distance from the head is below the count;
    // the head stays live until its write completes in WAIT_LO.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(i) - r_rd_ptr) < r_count) &&
                (r_fifo_addr[i][ADDR_WIDTH-1:2] == bus.cpu_addr[ADDR_WIDTH-1:2])) begin
                w_conflict = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_load || w_start_store) w_state_next = S_ISSUE;
            S_ISSUE:   w_state_next = S_WAIT_HI;
            S_WAIT_HI: if (bus.mem_clk_stall) w_state_next = S_WAIT_LO;
            S_WAIT_LO: if (!bus.mem_clk_stall) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_addr[r_wr_ptr] <= bus.cpu_addr;
            r_fifo_data[r_wr_ptr] <= bus.cpu_write_data;
            r_fifo_mask[r_wr_ptr] <= bus.cpu_sign_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_is_load   <= 1'b0;
            r_load_done <= 1'b0;
            r_load_data <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_mask  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Request registers are loaded only on entry to ISSUE, so they
            // read back as zero in every other state.
            if (w_start_load) begin
                r_mem_addr  <= bus.cpu_addr;
                r_mem_wdata <= '0;
                r_mem_we    <= 1'b0;
                r_mem_re    <= 1'b1;
                r_mem_mask  <= bus.cpu_sign_mask;
                r_is_load   <= 1'b1;
            end else if (w_start_store) begin
                r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                r_mem_wdata <= r_fifo_data[r_rd_ptr];
                r_mem_we    <= 1'b1;
                r_mem_re    <= 1'b0;
                r_mem_mask  <= r_fifo_mask[r_rd_ptr];
                r_is_load   <= 1'b0;
            end else begin
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
                r_mem_we    <= 1'b0;
                r_mem_re    <= 1'b0;
                r_mem_mask  <= '0;
            end

            if (w_complete && r_is_load) begin
                r_load_data <= bus.mem_read_data;
                r_load_done <= 1'b1;
            end else if (r_load_done) begin
                r_load_done <= 1'b0;
            end
        end
    end

    assign bus.cpu_stall      = (bus.cpu_memwrite & ~bus.cpu_memread & w_full) | w_load_pending;
    assign bus.cpu_read_data  = r_load_data;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_write_data = r_mem_wdata;
    assign bus.mem_memwrite   = r_mem_we;
    assign bus.mem_memread    = r_mem_re;
    assign bus.mem_sign_mask  = r_mem_mask;

endmodule
`default_nettype wire
